// File: rtl/htd_dec.sv
// htd_dec: head/tail tag decoder rebuilding sop/eop/length framing from a tagged word stream.
// Optional HTD_DEC_ERR_CNT_EN adds a saturating 16-bit protocol error counter on ov_err_cnt.
module htd_dec #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH:0]   iv_data,
  input  logic                  i_data_wr,
  output logic [DATA_WIDTH-1:0] ov_data,
  output logic                  o_data_wr,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [LEN_WIDTH-1:0]  ov_pkt_len,
  output logic                  o_pkt_len_wr,
  output logic                  o_err
`ifdef HTD_DEC_ERR_CNT_EN
  , output logic [15:0]         ov_err_cnt
`endif
);
  typedef enum logic {IDLE, BODY} state_t;
  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc, len_q, len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d, sop_q, sop_d, eop_q, eop_d, lw_q, lw_d, err_q, err_d;
  logic                  tag, sat;
  assign tag     = iv_data[DATA_WIDTH];
  assign sat     = &cnt_q;
  assign cnt_inc = sat ? cnt_q : cnt_q + LEN_WIDTH'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    len_d   = len_q;
    wr_d    = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    lw_d    = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE) begin
      if (i_data_wr && tag) begin
        wr_d    = 1'b1;
        data_d  = iv_data[DATA_WIDTH-1:0];
        sop_d   = 1'b1;
        cnt_d   = LEN_WIDTH'(1);
        state_d = BODY;
      end else if (i_data_wr) begin
        err_d = 1'b1;
      end
    end else if (!i_data_wr) begin
      // gap inside a packet: the open packet is abandoned, consumer drops it on o_err
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      wr_d   = 1'b1;
      data_d = iv_data[DATA_WIDTH-1:0];
      if (tag) begin
        eop_d   = 1'b1;
        lw_d    = 1'b1;
        len_d   = cnt_inc;
        err_d   = sat;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      lw_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      lw_q    <= lw_d;
      err_q   <= err_d;
    end
  end
  assign ov_data      = data_q;
  assign o_data_wr    = wr_q;
  assign o_sop        = sop_q;
  assign o_eop        = eop_q;
  assign ov_pkt_len   = len_q;
  assign o_pkt_len_wr = lw_q;
  assign o_err        = err_q;
`ifdef HTD_DEC_ERR_CNT_EN
  logic [15:0] ec_q, ec_d;
  assign ec_d = (err_d && !(&ec_q)) ? ec_q + 16'd1 : ec_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ec_q <= '0;
    else       ec_q <= ec_d;
  end
  assign ov_err_cnt = ec_q;
`endif
endmodule
